channel_reduce_arb: RTL and testbench
=====================================

CHANNEL_REDUCE_ARB -- requirements
Module: channel_reduce_arb

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of all channel words and the accumulator.
REQ-002 SHALL have parameter: BURST, 4, words reduced per grant; legal range 1..255.
REQ-003 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: in0_out_data  input  WIDTH  head word of channel 0.
REQ-006 SHALL have port: in0_read_ready  input  1  channel 0 holds at least one word.
REQ-007 SHALL have port: in0_read_valid  output  1  pop strobe to channel 0.
REQ-008 SHALL have ports: in1_out_data, in1_read_ready, in1_read_valid; same meaning for channel 1.
REQ-009 SHALL have port: out_in_data  output  WIDTH  reduced sum presented to the output channel.
REQ-010 SHALL have port: out_src  output  1  index of the channel that produced out_in_data.
REQ-011 SHALL have port: out_write_valid  output  1  sum offered to the output channel.
REQ-012 SHALL have port: out_write_ready  input  1  output channel accepts this cycle.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, READ, WRITE.
REQ-015 IDLE: when either read_ready is high, SHALL latch grant, clear acc and cnt, and enter READ on the next edge.
REQ-016 Grant SHALL be round-robin: if both channels are ready, grant the channel other than last_grant; if one is ready, grant that channel.
REQ-017 READ: in{g}_read_valid SHALL be a combinational function of state==READ, grant==g and in{g}_read_ready; the non-granted read_valid SHALL stay 0.
REQ-018 Each READ cycle with the pop asserted SHALL update acc <= acc + in{g}_out_data (modulo 2^WIDTH) and cnt <= cnt+1.
REQ-019 A READ cycle with granted read_ready low SHALL leave acc and cnt unchanged (stall); no timeout.
REQ-020 On the pop that makes cnt==BURST, SHALL enter WRITE on the next edge.
REQ-021 A grant SHALL NOT be pre-empted: the other channel's requests are ignored until the burst reaches WRITE.
REQ-022 WRITE: out_write_valid SHALL be 1, out_in_data SHALL equal acc, and out_src SHALL equal grant, all held stable until accepted.
REQ-023 WRITE with out_write_ready high SHALL complete the transfer, set last_grant <= grant, and return to IDLE; there SHALL be no back-to-back grant in that cycle.
REQ-024 Outside WRITE, out_write_valid SHALL be 0; out_in_data and out_src SHALL equal their registered values.
REQ-025 Minimum latency, first pop to out_write_valid: BURST cycles; grant-to-grant: BURST+2 cycles with no stalls.

Reset
REQ-026 rst low SHALL force, immediately and asynchronously: state=IDLE, acc=0, cnt=0, grant=0, last_grant=1 (so channel 0 wins the first tie).
REQ-027 Reset values of outputs: in0/in1_read_valid=0, out_write_valid=0, out_in_data=0, out_src=0, busy=0.
REQ-028 Reset during READ or WRITE SHALL discard the partial sum; no output write SHALL occur for that burst.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/READ/WRITE) and the default WIDTH/BURST constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: req[1:0], last; output: grant index and grant_valid), purely combinational.
REQ-031 Counter width SHALL be 8 bits; accumulator width SHALL be WIDTH.

Verification
REQ-032 Ch0 only, words 1,2,3,4, out_write_ready=1 -> out_in_data=10, out_src=0, out_write_valid high one cycle, 4 pops on in0_read_valid.
REQ-033 Both channels ready continuously, ch0=5s, ch1=7s -> outputs alternate 20(src0), 28(src1), 20(src0); no interleaved pops within a burst.
REQ-034 Ch1 words 0xFFFFFFFF x4 -> out_in_data=0xFFFFFFFC (wrap-around).
REQ-035 Ch0 read_ready drops for 3 cycles after the 2nd word -> acc holds, no pops, final sum is correct, latency = 4+3 cycles.
REQ-036 out_write_ready held low for 5 cycles in WRITE -> out_write_valid, out_in_data and out_src stable; no pops on either channel.
REQ-037 rst asserted low after the 2nd pop -> outputs zero immediately; after release, the next burst sum excludes the discarded words.

Source files
------------

// File: rtl/channel_reduce_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : channel_reduce_arb_pkg
// Description : Shared FSM state encoding and default sizing for the
//               two-channel reduce/arbitrate block.
// Revision    : 1.0 - initial release
// ============================================================================
package channel_reduce_arb_pkg;

    localparam int c_WIDTH_DEFAULT = 32;
    localparam int c_BURST_DEFAULT = 4;
    localparam int c_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage : channel_reduce_arb_pkg
`default_nettype wire

// File: rtl/channel_reduce_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester combinational round-robin pick; on a tie the
//               requester that did not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant       = 1'b0;
        grant_valid = |req;
        unique case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/channel_reduce_arb.sv
`default_nettype none
// ============================================================================
// Module      : channel_reduce_arb
// Description : Grants one of two input channels round-robin, sums BURST
//               words from it and offers the sum to the output channel.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_reduce_arb
    import channel_reduce_arb_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int BURST = c_BURST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_out_data,
    input  logic             in0_read_ready,
    output logic             in0_read_valid,
    input  logic [WIDTH-1:0] in1_out_data,
    input  logic             in1_read_ready,
    output logic             in1_read_valid,
    output logic [WIDTH-1:0] out_in_data,
    output logic             out_src,
    output logic             out_write_valid,
    input  logic             out_write_ready,
    output logic             busy
);

    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(BURST - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_grant;
    logic               r_last_grant;

    logic               w_arb_grant;
    logic               w_arb_valid;
    logic               w_start;
    logic               w_pop;
    logic               w_done;
    logic [WIDTH-1:0]   w_pop_data;

    rr_arb2 u_rr_arb2 (
        .req         ({in1_read_ready, in0_read_ready}),
        .last        (r_last_grant),
        .grant       (w_arb_grant),
        .grant_valid (w_arb_valid)
    );

    assign w_pop_data = r_grant ? in1_out_data : in0_out_data;

    always_comb begin
        w_state_nxt     = r_state;
        w_start         = 1'b0;
        w_pop           = 1'b0;
        w_done          = 1'b0;
        in0_read_valid  = 1'b0;
        in1_read_valid  = 1'b0;
        out_write_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                // Only the granted channel may pop; the other is ignored
                // until this burst has been written out.
                w_pop          = r_grant ? in1_read_ready : in0_read_ready;
                in0_read_valid = ~r_grant & in0_read_ready;
                in1_read_valid =  r_grant & in1_read_ready;
                if (w_pop && (r_cnt == c_LAST_CNT)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                out_write_valid = 1'b1;
                if (out_write_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_start) begin
                r_grant <= w_arb_grant;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (w_pop) begin
                r_acc <= r_acc + w_pop_data;
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Sum and source come straight from the working registers, so they are
    // stable for the whole WRITE state and zero out of reset.
    assign out_in_data = r_acc;
    assign out_src     = r_grant;
    assign busy        = (r_state != ST_IDLE);

endmodule : channel_reduce_arb
`default_nettype wire

// File: tb/tb_channel_reduce_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_reduce_arb
// Description : Directed self-checking bench for channel_reduce_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_reduce_arb;

    localparam int WIDTH = 32;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in0_out_data;
    logic             in0_read_ready;
    logic             in0_read_valid;
    logic [WIDTH-1:0] in1_out_data;
    logic             in1_read_ready;
    logic             in1_read_valid;
    logic [WIDTH-1:0] out_in_data;
    logic             out_src;
    logic             out_write_valid;
    logic             out_write_ready;
    logic             busy;

    channel_reduce_arb #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk             (clk),
        .rst             (rst),
        .in0_out_data    (in0_out_data),
        .in0_read_ready  (in0_read_ready),
        .in0_read_valid  (in0_read_valid),
        .in1_out_data    (in1_out_data),
        .in1_read_ready  (in1_read_ready),
        .in1_read_valid  (in1_read_valid),
        .out_in_data     (out_in_data),
        .out_src         (out_src),
        .out_write_valid (out_write_valid),
        .out_write_ready (out_write_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        en0, en1;
    int          pops0, pops1, both_pop, cyc, first_pop_cyc, wv_first_cyc, wv_cycles, pop_n;
    logic [63:0] pop_log;
    logic [31:0] wr_data[$];
    logic        wr_src[$];
    int          wr_cyc[$];
    int          hold_p0, hold_p1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_d(input int i);
        return (wr_data.size() > i) ? wr_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wr_s(input int i);
        return (wr_src.size() > i) ? 32'(wr_src[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic int wr_c(input int i);
        return (wr_cyc.size() > i) ? wr_cyc[i] : -1000;
    endfunction

    // Channel model: ready/head word follow the bench queues.
    task automatic refresh();
        in0_read_ready = en0 && (q0.size() > 0);
        in0_out_data   = (q0.size() > 0) ? q0[0] : '0;
        in1_read_ready = en1 && (q1.size() > 0);
        in1_out_data   = (q1.size() > 0) ? q1[0] : '0;
    endtask

    task automatic clear_stats();
        pops0 = 0; pops1 = 0; both_pop = 0; cyc = 0;
        first_pop_cyc = -1; wv_first_cyc = -1; wv_cycles = 0;
        pop_log = '0; pop_n = 0;
        wr_data.delete(); wr_src.delete(); wr_cyc.delete();
    endtask

    // One clock: sample strobes mid-cycle, then apply pops after the edge.
    task automatic cycle();
        logic s0, s1;
        @(negedge clk);
        s0 = in0_read_valid;
        s1 = in1_read_valid;
        if (s0) begin pops0++; pop_log = {pop_log[62:0], 1'b0}; pop_n++; end
        if (s1) begin pops1++; pop_log = {pop_log[62:0], 1'b1}; pop_n++; end
        if (s0 && s1) both_pop++;
        if ((s0 || s1) && first_pop_cyc < 0) first_pop_cyc = cyc;
        if (out_write_valid) begin
            wv_cycles++;
            if (wv_first_cyc < 0) wv_first_cyc = cyc;
            if (out_write_ready) begin
                wr_data.push_back(out_in_data);
                wr_src.push_back(out_src);
                wr_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s0 && q0.size() > 0) void'(q0.pop_front());
        if (s1 && q1.size() > 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic run_writes(input int n, input int budget);
        int k = 0;
        while (wr_data.size() < n && k < budget) begin
            cycle();
            k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        out_write_ready = 1'b0;
        q0.delete(); q1.delete();
        refresh();
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state, with channel 0 offering a word to prove strobes stay low
        rst = 1'b1;
        out_write_ready = 1'b1;
        en0 = 1'b1; en1 = 1'b1;
        q0.push_back(32'd9); q1.push_back(32'd9);
        refresh();
        clear_stats();
        #2 rst = 1'b0;
        #1;
        chk("rst_rv0", 32'(in0_read_valid), 32'd0);
        chk("rst_rv1", 32'(in1_read_valid), 32'd0);
        chk("rst_wv", 32'(out_write_valid), 32'd0);
        chk("rst_data", out_in_data, 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Channel 0 only: 1+2+3+4
        do_reset();
        q0 = '{32'd1, 32'd2, 32'd3, 32'd4};
        en0 = 1'b1; out_write_ready = 1'b1;
        refresh();
        run_writes(1, 30);
        repeat (2) cycle();
        chk("t1_nwr", 32'(wr_data.size()), 32'd1);
        chk("t1_sum", wr_d(0), 32'd10);
        chk("t1_src", wr_s(0), 32'd0);
        chk("t1_pops0", 32'(pops0), 32'd4);
        chk("t1_pops1", 32'(pops1), 32'd0);
        chk("t1_wvcyc", 32'(wv_cycles), 32'd1);
        chk("t1_lat", 32'(wv_first_cyc - first_pop_cyc), 32'd4);
        chk("t1_busy", 32'(busy), 32'd0);

        // Both channels always ready: alternating bursts
        do_reset();
        repeat (8) q0.push_back(32'd5);
        repeat (4) q1.push_back(32'd7);
        en0 = 1'b1; en1 = 1'b1; out_write_ready = 1'b1;
        refresh();
        run_writes(3, 60);
        chk("t2_sum0", wr_d(0), 32'd20);
        chk("t2_src0", wr_s(0), 32'd0);
        chk("t2_sum1", wr_d(1), 32'd28);
        chk("t2_src1", wr_s(1), 32'd1);
        chk("t2_sum2", wr_d(2), 32'd20);
        chk("t2_src2", wr_s(2), 32'd0);
        chk("t2_npops", 32'(pop_n), 32'd12);
        chk("t2_order", 32'(pop_log[11:0]), 32'b0000_1111_0000);
        chk("t2_both", 32'(both_pop), 32'd0);
        chk("t2_g2g", 32'(wr_c(1) - wr_c(0)), 32'd6);

        // Wrap-around on channel 1
        do_reset();
        repeat (4) q1.push_back(32'hFFFF_FFFF);
        en1 = 1'b1; out_write_ready = 1'b1;
        refresh();
        run_writes(1, 30);
        chk("t3_sum", wr_d(0), 32'hFFFF_FFFC);
        chk("t3_src", wr_s(0), 32'd1);

        // Stall of three cycles after the second word
        do_reset();
        q0 = '{32'd10, 32'd20, 32'd30, 32'd40};
        en0 = 1'b1; out_write_ready = 1'b1;
        refresh();
        for (int k = 0; k < 30 && pops0 < 2; k++) cycle();
        en0 = 1'b0;
        refresh();
        repeat (3) cycle();
        chk("t4_stall_pops", 32'(pops0), 32'd2);
        en0 = 1'b1;
        refresh();
        run_writes(1, 30);
        chk("t4_sum", wr_d(0), 32'd100);
        chk("t4_lat", 32'(wv_first_cyc - first_pop_cyc), 32'd7);
        chk("t4_pops0", 32'(pops0), 32'd4);

        // Output back-pressure for five cycles; channel 1 must not pre-empt
        do_reset();
        q0 = '{32'd7, 32'd8, 32'd9, 32'd10};
        q1 = '{32'd1, 32'd1, 32'd1, 32'd1};
        en0 = 1'b1; en1 = 1'b1; out_write_ready = 1'b0;
        refresh();
        for (int k = 0; k < 30 && wv_first_cyc < 0; k++) cycle();
        hold_p0 = pops0;
        hold_p1 = pops1;
        for (int k = 0; k < 5; k++) begin
            chk("t5_wv", 32'(out_write_valid), 32'd1);
            chk("t5_data", out_in_data, 32'd34);
            chk("t5_src", 32'(out_src), 32'd0);
            cycle();
        end
        chk("t5_hold_pops0", 32'(pops0 - hold_p0), 32'd0);
        chk("t5_hold_pops1", 32'(pops1 - hold_p1), 32'd0);
        chk("t5_pops0", 32'(pops0), 32'd4);
        chk("t5_pops1", 32'(pops1), 32'd0);
        out_write_ready = 1'b1;
        cycle();
        chk("t5_nwr", 32'(wr_data.size()), 32'd1);
        chk("t5_sum", wr_d(0), 32'd34);

        // Reset after the second pop discards the partial burst
        do_reset();
        q0 = '{32'd100, 32'd200, 32'd300, 32'd400};
        en0 = 1'b1; out_write_ready = 1'b1;
        refresh();
        for (int k = 0; k < 30 && pops0 < 2; k++) cycle();
        chk("t6_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rv0", 32'(in0_read_valid), 32'd0);
        chk("t6_wv", 32'(out_write_valid), 32'd0);
        chk("t6_data", out_in_data, 32'd0);
        chk("t6_src", 32'(out_src), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.push_back(32'd5);
        q0.push_back(32'd6);
        clear_stats();
        refresh();
        run_writes(1, 30);
        chk("t6_sum", wr_d(0), 32'd711);
        chk("t6_pops0", 32'(pops0), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_channel_reduce_arb
`default_nettype wire
